// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM port arbiter: FSM states,
// grant encoding and the byte returned when an access times out.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT,
    ARB_DONE
  } arb_state_e;

  typedef logic [1:0] grant_t;

  localparam grant_t GNT_DL   = 2'd0;
  localparam grant_t GNT_CAS  = 2'd1;
  localparam grant_t GNT_CART = 2'd2;

  localparam logic [7:0] TIMEOUT_DATA = 8'hFF;

endpackage

// File: rtl/sdram_arb_pick.sv
// Combinational winner select for the SDRAM port. Download always wins;
// cas/cart use fixed priority unless SDRAM_ARB_RR_EN selects round-robin.
module sdram_arb_pick
  import sdram_arb_pkg::*;
(
  input  logic       dl_pend_i,
  input  logic       cas_req_i,
  input  logic       cart_req_i,
  input  logic       last_cart_i,
  output logic       valid_o,
  output logic [1:0] grant_o
);

`ifndef SDRAM_ARB_RR_EN
  logic unused_last_cart;
  assign unused_last_cart = last_cart_i;
`endif

  always_comb begin
    // NOTE: every output gets a default first so no latch is inferred.
    valid_o = dl_pend_i | cas_req_i | cart_req_i;
    grant_o = GNT_DL;
    if (dl_pend_i) begin
      grant_o = GNT_DL;
    end else if (cas_req_i && cart_req_i) begin
`ifdef SDRAM_ARB_RR_EN
      // Tie goes to whichever reader was not granted last.
      grant_o = last_cart_i ? GNT_CAS : GNT_CART;
`else
      grant_o = GNT_CAS;
`endif
    end else if (cas_req_i) begin
      grant_o = GNT_CAS;
    end else if (cart_req_i) begin
      grant_o = GNT_CART;
    end
  end

endmodule

// File: rtl/sdram_port_arb.sv
// Shares the single 8-bit SDRAM port between the download writer, cassette
// and cartridge readers. Optional round-robin readers: SDRAM_ARB_RR_EN.
module sdram_port_arb
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W  = 25,
  parameter int TIMEOUT = 31
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              dl_wr_i,
  input  logic [ADDR_W-1:0] dl_addr_i,
  input  logic [7:0]        dl_data_i,
  output logic              dl_ovf_o,
  input  logic              cas_req_i,
  input  logic [ADDR_W-1:0] cas_addr_i,
  output logic              cas_ack_o,
  output logic [7:0]        cas_data_o,
  input  logic              cart_req_i,
  input  logic [ADDR_W-1:0] cart_addr_i,
  output logic              cart_ack_o,
  output logic [7:0]        cart_data_o,
  output logic [ADDR_W-1:0] sd_addr_o,
  output logic [7:0]        sd_din_o,
  output logic              sd_rd_o,
  output logic              sd_we_o,
  input  logic [7:0]        sd_dout_i,
  input  logic              sd_ready_i,
  output logic              busy_o,
  output logic              tmo_err_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  arb_state_e        state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic              last_cart_q, last_cart_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              dl_pend_q, dl_pend_d;
  logic [ADDR_W-1:0] dl_addr_q, dl_addr_d;
  logic [7:0]        dl_data_q, dl_data_d;
  logic              dl_ovf_q, dl_ovf_d;
  logic              tmo_q, tmo_d;
  logic [7:0]        cas_data_q, cas_data_d;
  logic [7:0]        cart_data_q, cart_data_d;
  logic [ADDR_W-1:0] sd_addr_q, sd_addr_d;
  logic [7:0]        sd_din_q, sd_din_d;

  logic              pick_valid;
  logic [1:0]        pick_grant;
  logic              timed_out;
  logic              wait_end;
  logic              dl_done;
  logic [7:0]        rd_byte;

  // A strobe in the IDLE cycle competes immediately instead of a cycle late.
  sdram_arb_pick u_pick (
    .dl_pend_i  (dl_pend_q | dl_wr_i),
    .cas_req_i  (cas_req_i),
    .cart_req_i (cart_req_i),
    .last_cart_i(last_cart_q),
    .valid_o    (pick_valid),
    .grant_o    (pick_grant)
  );

  assign timed_out = (cnt_q == CNT_W'(TIMEOUT));
  assign wait_end  = sd_ready_i | timed_out;
  assign dl_done   = (state_q == ARB_DONE) && (grant_q == GNT_DL);
  assign rd_byte   = sd_ready_i ? sd_dout_i : TIMEOUT_DATA;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ARB_IDLE;
    end else begin
      // NOTE: sequential state always uses non-blocking assignment.
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE:  if (pick_valid) state_d = ARB_ISSUE;
      ARB_ISSUE: state_d = ARB_WAIT;
      ARB_WAIT:  if (wait_end) state_d = ARB_DONE;
      ARB_DONE:  state_d = ARB_IDLE;
      default:   state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    sd_rd_o    = (state_q == ARB_ISSUE) && (grant_q != GNT_DL);
    sd_we_o    = (state_q == ARB_ISSUE) && (grant_q == GNT_DL);
    cas_ack_o  = (state_q == ARB_DONE)  && (grant_q == GNT_CAS);
    cart_ack_o = (state_q == ARB_DONE)  && (grant_q == GNT_CART);
    busy_o     = (state_q != ARB_IDLE)  || dl_pend_q;
  end

  always_comb begin
    grant_d     = grant_q;
    last_cart_d = last_cart_q;
    cnt_d       = cnt_q;
    dl_pend_d   = dl_pend_q;
    dl_addr_d   = dl_addr_q;
    dl_data_d   = dl_data_q;
    dl_ovf_d    = dl_ovf_q;
    tmo_d       = tmo_q;
    cas_data_d  = cas_data_q;
    cart_data_d = cart_data_q;
    sd_addr_d   = sd_addr_q;
    sd_din_d    = sd_din_q;

    // A strobe landing on the download's own DONE re-arms without overflow.
    if (dl_wr_i) begin
      dl_pend_d = 1'b1;
      dl_addr_d = dl_addr_i;
      dl_data_d = dl_data_i;
      if (dl_pend_q && !dl_done) dl_ovf_d = 1'b1;
    end else if (dl_done) begin
      dl_pend_d = 1'b0;
    end

    unique case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          grant_d = pick_grant;
          unique case (pick_grant)
            GNT_DL: begin
              sd_addr_d = dl_wr_i ? dl_addr_i : dl_addr_q;
              sd_din_d  = dl_wr_i ? dl_data_i : dl_data_q;
            end
            GNT_CAS: begin
              sd_addr_d   = cas_addr_i;
              last_cart_d = 1'b0;
            end
            default: begin
              sd_addr_d   = cart_addr_i;
              last_cart_d = 1'b1;
            end
          endcase
        end
      end
      ARB_ISSUE: cnt_d = '0;
      ARB_WAIT: begin
        if (wait_end) begin
          if (!sd_ready_i) tmo_d = 1'b1;
          if (grant_q == GNT_CAS)  cas_data_d  = rd_byte;
          if (grant_q == GNT_CART) cart_data_d = rd_byte;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      grant_q     <= GNT_DL;
      last_cart_q <= 1'b1;
      cnt_q       <= '0;
      dl_pend_q   <= 1'b0;
      dl_addr_q   <= '0;
      dl_data_q   <= '0;
      dl_ovf_q    <= 1'b0;
      tmo_q       <= 1'b0;
      // NOTE: the read-data registers are reset since their value is visible.
      cas_data_q  <= '0;
      cart_data_q <= '0;
      sd_addr_q   <= '0;
      sd_din_q    <= '0;
    end else begin
      grant_q     <= grant_d;
      last_cart_q <= last_cart_d;
      cnt_q       <= cnt_d;
      dl_pend_q   <= dl_pend_d;
      dl_addr_q   <= dl_addr_d;
      dl_data_q   <= dl_data_d;
      dl_ovf_q    <= dl_ovf_d;
      tmo_q       <= tmo_d;
      cas_data_q  <= cas_data_d;
      cart_data_q <= cart_data_d;
      sd_addr_q   <= sd_addr_d;
      sd_din_q    <= sd_din_d;
    end
  end

  assign dl_ovf_o    = dl_ovf_q;
  assign tmo_err_o   = tmo_q;
  assign cas_data_o  = cas_data_q;
  assign cart_data_o = cart_data_q;
  assign sd_addr_o   = sd_addr_q;
  assign sd_din_o    = sd_din_q;

endmodule

// File: tb/tb_sdram_port_arb.sv
// Directed bench for sdram_port_arb; round-robin expectations follow
// SDRAM_ARB_RR_EN when the bench is built with it.
module tb_sdram_port_arb;

  localparam int ADDR_W = 25;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              dl_wr_i = 1'b0;
  logic [ADDR_W-1:0] dl_addr_i = '0;
  logic [7:0]        dl_data_i = '0;
  logic              dl_ovf_o;
  logic              cas_req_i = 1'b0;
  logic [ADDR_W-1:0] cas_addr_i = '0;
  logic              cas_ack_o;
  logic [7:0]        cas_data_o;
  logic              cart_req_i = 1'b0;
  logic [ADDR_W-1:0] cart_addr_i = '0;
  logic              cart_ack_o;
  logic [7:0]        cart_data_o;
  logic [ADDR_W-1:0] sd_addr_o;
  logic [7:0]        sd_din_o;
  logic              sd_rd_o;
  logic              sd_we_o;
  logic [7:0]        sd_dout_i = '0;
  logic              sd_ready_i = 1'b0;
  logic              busy_o;
  logic              tmo_err_o;

  int checks = 0;
  int failures = 0;

  sdram_port_arb #(.ADDR_W(ADDR_W), .TIMEOUT(31)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .dl_wr_i    (dl_wr_i),
    .dl_addr_i  (dl_addr_i),
    .dl_data_i  (dl_data_i),
    .dl_ovf_o   (dl_ovf_o),
    .cas_req_i  (cas_req_i),
    .cas_addr_i (cas_addr_i),
    .cas_ack_o  (cas_ack_o),
    .cas_data_o (cas_data_o),
    .cart_req_i (cart_req_i),
    .cart_addr_i(cart_addr_i),
    .cart_ack_o (cart_ack_o),
    .cart_data_o(cart_data_o),
    .sd_addr_o  (sd_addr_o),
    .sd_din_o   (sd_din_o),
    .sd_rd_o    (sd_rd_o),
    .sd_we_o    (sd_we_o),
    .sd_dout_i  (sd_dout_i),
    .sd_ready_i (sd_ready_i),
    .busy_o     (busy_o),
    .tmo_err_o  (tmo_err_o)
  );

  always #5 clk_i = ~clk_i;

  // Inputs change and outputs are sampled 1 ns after each rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    dl_wr_i = 1'b0; cas_req_i = 1'b0; cart_req_i = 1'b0; sd_ready_i = 1'b0;
    tick(); tick();
    rst_ni = 1'b1;
    tick();
  endtask

  // Called in the ISSUE cycle: ready arrives `lat` cycles later; returns in DONE.
  task automatic serve(input int lat, input logic [7:0] dout);
    repeat (lat - 1) tick();
    tick();
    sd_ready_i = 1'b1;
    sd_dout_i  = dout;
    tick();
    sd_ready_i = 1'b0;
  endtask

  task automatic wait_cmd(input string name);
    int n = 0;
    while (!(sd_rd_o || sd_we_o) && n < 64) begin
      tick();
      n++;
    end
    checks++;
    if (!(sd_rd_o || sd_we_o)) begin
      failures++;
      $display("FAIL %s: no sd_rd/sd_we within 64 cycles", name);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({sd_rd_o, sd_we_o, cas_ack_o, cart_ack_o, busy_o, dl_ovf_o, tmo_err_o} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b want 0000000",
               {sd_rd_o, sd_we_o, cas_ack_o, cart_ack_o, busy_o, dl_ovf_o, tmo_err_o});
    end
    checks++;
    if ({sd_addr_o, sd_din_o, cas_data_o, cart_data_o} !== '0) begin
      failures++;
      $display("FAIL reset_data: addr=%h din=%h cas=%h cart=%h want all 0",
               sd_addr_o, sd_din_o, cas_data_o, cart_data_o);
    end
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    cas_req_i = 1'b1; cas_addr_i = 25'h00123;
    tick();
    checks++;
    if (sd_rd_o !== 1'b1 || sd_we_o !== 1'b0 || sd_addr_o !== 25'h00123) begin
      failures++;
      $display("FAIL single_issue: rd=%b we=%b addr=%h want 1 0 00123", sd_rd_o, sd_we_o, sd_addr_o);
    end
    tick();
    sd_ready_i = 1'b1; sd_dout_i = 8'h5A;
    checks++;
    if (sd_rd_o !== 1'b0 || cas_ack_o !== 1'b0) begin
      failures++;
      $display("FAIL single_wait: rd=%b ack=%b want 0 0", sd_rd_o, cas_ack_o);
    end
    tick();
    sd_ready_i = 1'b0; sd_dout_i = 8'h00;
    checks++;
    if (cas_ack_o !== 1'b1 || cas_data_o !== 8'h5A) begin
      failures++;
      $display("FAIL single_ack: ack=%b data=%h want 1 5a", cas_ack_o, cas_data_o);
    end
    cas_req_i = 1'b0;
    tick();
    checks++;
    if (cas_ack_o !== 1'b0 || cas_data_o !== 8'h5A || busy_o !== 1'b0 || sd_addr_o !== 25'h00123) begin
      failures++;
      $display("FAIL single_hold: ack=%b data=%h busy=%b addr=%h want 0 5a 0 00123",
               cas_ack_o, cas_data_o, busy_o, sd_addr_o);
    end
  endtask

  task automatic test_reset_mid();
    cas_req_i = 1'b1; cas_addr_i = 25'h00500;
    tick();
    tick();
    rst_ni = 1'b0;
    #1;
    checks++;
    if ({sd_rd_o, cas_ack_o, busy_o} !== 3'b0 || sd_addr_o !== '0 || cas_data_o !== 8'h00) begin
      failures++;
      $display("FAIL reset_mid: rd=%b ack=%b busy=%b addr=%h data=%h want 0 0 0 0 00",
               sd_rd_o, cas_ack_o, busy_o, sd_addr_o, cas_data_o);
    end
    tick(); tick();
    rst_ni = 1'b1;
    tick();
    checks++;
    if (sd_rd_o !== 1'b1 || sd_addr_o !== 25'h00500) begin
      failures++;
      $display("FAIL reset_resume: rd=%b addr=%h want 1 00500", sd_rd_o, sd_addr_o);
    end
    serve(1, 8'hC3);
    checks++;
    if (cas_ack_o !== 1'b1 || cas_data_o !== 8'hC3) begin
      failures++;
      $display("FAIL reset_resume_ack: ack=%b data=%h want 1 c3", cas_ack_o, cas_data_o);
    end
    cas_req_i = 1'b0;
    tick();
  endtask

  task automatic test_dl_and_cas();
    dl_wr_i = 1'b1; dl_addr_i = 25'h00456; dl_data_i = 8'hA5;
    cas_req_i = 1'b1; cas_addr_i = 25'h00123;
    tick();
    dl_wr_i = 1'b0;
    checks++;
    if (sd_we_o !== 1'b1 || sd_rd_o !== 1'b0 || sd_addr_o !== 25'h00456 || sd_din_o !== 8'hA5) begin
      failures++;
      $display("FAIL dl_first: we=%b rd=%b addr=%h din=%h want 1 0 00456 a5",
               sd_we_o, sd_rd_o, sd_addr_o, sd_din_o);
    end
    serve(1, 8'h00);
    checks++;
    if (busy_o !== 1'b1 || cas_ack_o !== 1'b0) begin
      failures++;
      $display("FAIL dl_done: busy=%b cas_ack=%b want 1 0", busy_o, cas_ack_o);
    end
    wait_cmd("dl_then_cas");
    checks++;
    if (sd_rd_o !== 1'b1 || sd_addr_o !== 25'h00123 || dl_ovf_o !== 1'b0) begin
      failures++;
      $display("FAIL cas_second: rd=%b addr=%h ovf=%b want 1 00123 0", sd_rd_o, sd_addr_o, dl_ovf_o);
    end
    serve(1, 8'h3C);
    checks++;
    if (cas_ack_o !== 1'b1 || cas_data_o !== 8'h3C) begin
      failures++;
      $display("FAIL cas_second_ack: ack=%b data=%h want 1 3c", cas_ack_o, cas_data_o);
    end
    cas_req_i = 1'b0;
    tick();
  endtask

  task automatic test_dl_rearm();
    dl_wr_i = 1'b1; dl_addr_i = 25'h00030; dl_data_i = 8'h31;
    tick();
    dl_wr_i = 1'b0;
    serve(1, 8'h00);
    dl_wr_i = 1'b1; dl_addr_i = 25'h00040; dl_data_i = 8'h41;
    tick();
    dl_wr_i = 1'b0;
    checks++;
    if (dl_ovf_o !== 1'b0 || busy_o !== 1'b1) begin
      failures++;
      $display("FAIL rearm_pend: ovf=%b busy=%b want 0 1", dl_ovf_o, busy_o);
    end
    tick();
    checks++;
    if (sd_we_o !== 1'b1 || sd_addr_o !== 25'h00040 || sd_din_o !== 8'h41) begin
      failures++;
      $display("FAIL rearm_write: we=%b addr=%h din=%h want 1 00040 41", sd_we_o, sd_addr_o, sd_din_o);
    end
    serve(1, 8'h00);
    tick();
    checks++;
    if (busy_o !== 1'b0 || dl_ovf_o !== 1'b0) begin
      failures++;
      $display("FAIL rearm_idle: busy=%b ovf=%b want 0 0", busy_o, dl_ovf_o);
    end
  endtask

  task automatic test_ovf();
    cas_req_i = 1'b1; cas_addr_i = 25'h00200;
    tick();
    tick();
    dl_wr_i = 1'b1; dl_addr_i = 25'h00010; dl_data_i = 8'h11;
    tick();
    dl_wr_i = 1'b0;
    checks++;
    if (dl_ovf_o !== 1'b0) begin
      failures++;
      $display("FAIL ovf_first: ovf=%b want 0", dl_ovf_o);
    end
    tick();
    dl_wr_i = 1'b1; dl_addr_i = 25'h00020; dl_data_i = 8'h22;
    tick();
    dl_wr_i = 1'b0;
    checks++;
    if (dl_ovf_o !== 1'b1) begin
      failures++;
      $display("FAIL ovf_second: ovf=%b want 1", dl_ovf_o);
    end
    repeat (6) tick();
    sd_ready_i = 1'b1; sd_dout_i = 8'h77;
    tick();
    sd_ready_i = 1'b0;
    checks++;
    if (cas_ack_o !== 1'b1 || cas_data_o !== 8'h77) begin
      failures++;
      $display("FAIL ovf_cas_ack: ack=%b data=%h want 1 77", cas_ack_o, cas_data_o);
    end
    cas_req_i = 1'b0;
    tick();
    tick();
    checks++;
    if (sd_we_o !== 1'b1 || sd_addr_o !== 25'h00020 || sd_din_o !== 8'h22) begin
      failures++;
      $display("FAIL ovf_write: we=%b addr=%h din=%h want 1 00020 22", sd_we_o, sd_addr_o, sd_din_o);
    end
    serve(1, 8'h00);
    tick();
    checks++;
    if (busy_o !== 1'b0 || dl_ovf_o !== 1'b1) begin
      failures++;
      $display("FAIL ovf_sticky: busy=%b ovf=%b want 0 1", busy_o, dl_ovf_o);
    end
  endtask

  task automatic test_timeout();
    cas_req_i = 1'b1; cas_addr_i = 25'h00300;
    tick();
    checks++;
    if (sd_rd_o !== 1'b1) begin
      failures++;
      $display("FAIL tmo_issue: rd=%b want 1", sd_rd_o);
    end
    repeat (32) tick();
    checks++;
    if (cas_ack_o !== 1'b0 || tmo_err_o !== 1'b0) begin
      failures++;
      $display("FAIL tmo_early: ack=%b tmo=%b at N+33 want 0 0", cas_ack_o, tmo_err_o);
    end
    tick();
    checks++;
    if (cas_ack_o !== 1'b1 || cas_data_o !== 8'hFF || tmo_err_o !== 1'b1) begin
      failures++;
      $display("FAIL tmo_ack: ack=%b data=%h tmo=%b at N+34 want 1 ff 1", cas_ack_o, cas_data_o, tmo_err_o);
    end
    cas_req_i = 1'b0;
    cart_req_i = 1'b1; cart_addr_i = 25'h00400;
    wait_cmd("tmo_next");
    checks++;
    if (sd_rd_o !== 1'b1 || sd_addr_o !== 25'h00400) begin
      failures++;
      $display("FAIL tmo_next_issue: rd=%b addr=%h want 1 00400", sd_rd_o, sd_addr_o);
    end
    serve(2, 8'h99);
    checks++;
    if (cart_ack_o !== 1'b1 || cart_data_o !== 8'h99 || tmo_err_o !== 1'b1) begin
      failures++;
      $display("FAIL tmo_next_ack: ack=%b data=%h tmo=%b want 1 99 1", cart_ack_o, cart_data_o, tmo_err_o);
    end
    cart_req_i = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic exp_cas;
    logic [7:0] dout;
    cas_req_i = 1'b1; cas_addr_i = 25'h00111;
    cart_req_i = 1'b1; cart_addr_i = 25'h00222;
    for (int k = 0; k < 3; k++) begin
`ifdef SDRAM_ARB_RR_EN
      exp_cas = (k != 1);
`else
      exp_cas = 1'b1;
`endif
      dout = 8'h40 + 8'(k);
      wait_cmd("b2b_cmd");
      checks++;
      if (sd_rd_o !== 1'b1 || sd_addr_o !== (exp_cas ? 25'h00111 : 25'h00222)) begin
        failures++;
        $display("FAIL b2b_issue[%0d]: rd=%b addr=%h want cas=%b", k, sd_rd_o, sd_addr_o, exp_cas);
      end
      serve(1, dout);
      checks++;
      if (cas_ack_o !== exp_cas || cart_ack_o !== !exp_cas ||
          (exp_cas ? cas_data_o : cart_data_o) !== dout) begin
        failures++;
        $display("FAIL b2b_ack[%0d]: cas_ack=%b cart_ack=%b cas=%h cart=%h want cas_ack=%b data=%h",
                 k, cas_ack_o, cart_ack_o, cas_data_o, cart_data_o, exp_cas, dout);
      end
      tick();
    end
    cas_req_i = 1'b0; cart_req_i = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_reset_mid();
    do_reset();
    test_dl_and_cas();
    do_reset();
    test_dl_rearm();
    do_reset();
    test_ovf();
    do_reset();
    test_timeout();
    do_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
